// File: rtl/vga_pkg.sv
// vga_pkg: default XGA 1024x768@60 (65 MHz pclk) timing and the shared count width.
package vga_pkg;
  localparam int CNT_W    = 11;
  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam bit SYNC_POL = 1'b0;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-stream timing bundle; frame_cnt exists only with VGA_TIMING_FRAME_CNT_EN.
interface vga_timing_gen_if;
  import vga_pkg::*;
  logic [CNT_W-1:0] hcount_out;
  logic [CNT_W-1:0] vcount_out;
  logic hsync_out;
  logic vsync_out;
  logic hblnk_out;
  logic vblnk_out;
  logic line_start;
  logic frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  modport master (output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                  line_start, frame_start, frame_cnt);
  modport slave  (input hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                  line_start, frame_start, frame_cnt);
`else
  modport master (output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                  line_start, frame_start);
  modport slave  (input hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                  line_start, frame_start);
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis; wrap counter with carry-out and sync/blank registered from the next count.
module vga_axis_counter import vga_pkg::*; #(
  parameter int TOTAL      = H_TOTAL,
  parameter int ACTIVE     = H_ACTIVE,
  parameter int SYNC_START = H_ACTIVE + H_FP,
  parameter int SYNC_LEN   = H_SYNC,
  parameter bit POL        = SYNC_POL
)(
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             carry,
  output logic             sync,
  output logic             blnk
);
  logic [CNT_W-1:0] nxt;
  logic             in_sync;
  assign carry   = en && cnt == CNT_W'(TOTAL - 1);
  assign nxt     = carry ? '0 : en ? cnt + 1'b1 : cnt;
  assign in_sync = nxt >= CNT_W'(SYNC_START) && nxt <= CNT_W'(SYNC_START + SYNC_LEN - 1);
  // decoding from nxt keeps the flags cycle-aligned with cnt
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      sync <= !POL;
      blnk <= 1'b0;
    end else begin
      cnt  <= nxt;
      sync <= in_sync ? POL : !POL;
      blnk <= nxt >= CNT_W'(ACTIVE);
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered pixel-timing source at the head of the video pipeline.
// Defining VGA_TIMING_FRAME_CNT_EN adds the 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter bit SYNC_POL = vga_pkg::SYNC_POL
)(
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             en,
  vga_timing_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_range
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit count range");
  end
  logic h_carry;
  logic v_carry;
  logic line_start;
  logic frame_start;
  vga_axis_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC), .POL(SYNC_POL)
  ) u_h (
    .pclk(pclk), .rst_n(rst_n), .en(en), .cnt(vid.hcount_out), .carry(h_carry),
    .sync(vid.hsync_out), .blnk(vid.hblnk_out)
  );
  vga_axis_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC), .POL(SYNC_POL)
  ) u_v (
    .pclk(pclk), .rst_n(rst_n), .en(h_carry), .cnt(vid.vcount_out), .carry(v_carry),
    .sync(vid.vsync_out), .blnk(vid.vblnk_out)
  );
  // a carry out of an axis is exactly the step that lands on count 0
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else if (en) begin
      line_start  <= h_carry;
      frame_start <= v_carry;
    end
  assign vid.line_start  = line_start;
  assign vid.frame_start = frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) frame_cnt <= '0;
    else if (v_carry) frame_cnt <= frame_cnt + 16'd1;
  assign vid.frame_cnt = frame_cnt;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized-enable scoreboard bench on a reduced geometry so whole frames stay short.
module tb_vga_timing_gen;
  localparam int HA = 20, HF = 2, HS = 3, HB = 4;
  localparam int VA = 10, VF = 1, VS = 2, VB = 3;
  localparam bit POL = 1'b0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } vec_t;

  logic pclk = 1'b0;
  logic rst_n;
  logic en;
  int   checks = 0;
  int   errors = 0;
  int   p;
  logic [15:0] fc;
  vec_t sb[$];

  vga_timing_gen_if vif ();
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
  ) dut (.pclk(pclk), .rst_n(rst_n), .en(en), .vid(vif));

  always #5 pclk = ~pclk;

  // reference: position is a linear pixel index within the frame
  function automatic vec_t expect_of(int pos, logic [15:0] f);
    vec_t r;
    int h;
    int v;
    h = pos % HT;
    v = pos / HT;
    r.h  = 11'(h);
    r.v  = 11'(v);
    r.hs = (h >= HA + HF && h < HA + HF + HS) ? POL : !POL;
    r.vs = (v >= VA + VF && v < VA + VF + VS) ? POL : !POL;
    r.hb = h >= HA;
    r.vb = v >= VA;
    r.ls = h == 0;
    r.fs = pos == 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    r.fc = f;
`else
    r.fc = f & 16'h0;
`endif
    return r;
  endfunction

  function automatic vec_t act();
    vec_t r;
    r.h  = vif.hcount_out;
    r.v  = vif.vcount_out;
    r.hs = vif.hsync_out;
    r.vs = vif.vsync_out;
    r.hb = vif.hblnk_out;
    r.vb = vif.vblnk_out;
    r.ls = vif.line_start;
    r.fs = vif.frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    r.fc = vif.frame_cnt;
`else
    r.fc = '0;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input vec_t a, input vec_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d",
               name, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.ls, a.fs, a.fc,
               e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.ls, e.fs, e.fc);
    end
  endtask

  task automatic step(input bit e);
    @(negedge pclk);
    en = e;
    if (e) begin
      p = (p + 1) % FT;
      if (p == 0) fc = fc + 16'd1;
    end
    sb.push_back(expect_of(p, fc));
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (p != target && n < 4 * FT) begin
      step($urandom_range(0, 3) != 0);
      n++;
    end
    if (p != target) begin
      checks++;
      errors++;
      $display("FAIL run_to: position %0d, wanted %0d within budget", p, target);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge pclk);
      #1;
      if (sb.size() != 0) chk("stream", act(), sb.pop_front());
    end
  end

  initial begin : stim
    en = 1'b0;
    rst_n = 1'b0;
    p = 0;
    fc = '0;
    repeat (5) @(negedge pclk);
    chk("reset", act(), expect_of(0, 16'd0));
    rst_n = 1'b1;
    repeat (HT) step(1'b1);
    run_to(2 * HT + HA + HF - 1);
    repeat (10) step(1'b0);
    step(1'b1);
    repeat (3 * FT) step($urandom_range(0, 3) != 0);
    run_to(6 * HT + 12);
    @(posedge pclk);
    #3;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("async_reset", act(), expect_of(0, 16'd0));
    p = 0;
    fc = '0;
    repeat (3) @(negedge pclk);
    chk("reset_hold", act(), expect_of(0, 16'd0));
    rst_n = 1'b1;
    repeat (FT + 50) step($urandom_range(0, 3) != 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    run_to(FT - 5);
    @(negedge pclk);
    en = 1'b0;
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    fc = 16'hFFFF;
    repeat (20) step(1'b1);
`endif
    repeat (3) @(negedge pclk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
